stopwatch_ctrl: RTL

// Control/sequencing front end for the stopwatch BCD counter datapath. Debounces the

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/stopwatch_if.sv | 21 ++
 rtl/key_debounce.sv | 52 +++++
 rtl/stopwatch_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and 50 MHz default timing constants for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } sw_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned TICK_CYCLES_DEF     = 500_000;
  localparam int unsigned CW_DEF              = 32;

endpackage

// File: rtl/stopwatch_if.sv
// Key inputs and datapath control outputs of the stopwatch controller.
interface stopwatch_if;
  logic       key_start_pause;
  logic       key_display_stop;
  logic       key_clear;
  logic       tick;
  logic       disp_en;
  logic       clear;
  logic       run;
  logic [3:0] led;

  modport master (
    output key_start_pause, key_display_stop, key_clear,
    input  tick, disp_en, clear, run, led
  );

  modport slave (
    input  key_start_pause, key_display_stop, key_clear,
    output tick, disp_en, clear, run, led
  );
endinterface

// File: rtl/key_debounce.sv
// Active-low key: 2-FF synchronizer plus stable-level counter; one press pulse per press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CW              = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          armed;
  logic          level_ok;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // Armed: counting a stable press. Disarmed: counting a stable release before re-arm.
  assign level_ok = armed ? !sync2 : sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (!level_ok) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        armed <= !armed;
        press <= armed;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: debounced keys, start/pause/clear FSM, 10 ms prescaler.
//   state   | meaning
//   IDLE    | stopped and zeroed, prescaler held at 0
//   RUNNING | prescaler counting, tick issued on each wrap
//   PAUSED  | prescaler held mid-interval, resume finishes it
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TICK_CYCLES     = TICK_CYCLES_DEF,
  parameter int unsigned CW              = CW_DEF
) (
  input  logic        clk,
  input  logic        key_reset,
  stopwatch_if.slave  sw
);

  localparam logic [CW-1:0] PRESC_LAST = CW'(TICK_CYCLES - 1);

  logic          press_sp;
  logic          press_ds;
  logic          press_cl;
  logic          go_sp;
  logic          go_ds;
  sw_state_t     state;
  sw_state_t     state_nx;
  logic [CW-1:0] presc;
  logic [CW-1:0] presc_nx;
  logic          frozen;
  logic          frozen_nx;
  logic          clear_q;
  logic          clear_nx;
  logic          tick_tgl;
  logic          wrap;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CW(CW)) u_db_sp (
    .clk(clk), .rst_n(key_reset), .key(sw.key_start_pause), .press(press_sp)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CW(CW)) u_db_ds (
    .clk(clk), .rst_n(key_reset), .key(sw.key_display_stop), .press(press_ds)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CW(CW)) u_db_cl (
    .clk(clk), .rst_n(key_reset), .key(sw.key_clear), .press(press_cl)
  );

  // Clear outranks start/pause, which outranks display stop; losers are dropped.
  assign go_sp = press_sp && !press_cl;
  assign go_ds = press_ds && !press_cl && !press_sp;

  assign wrap = (state == RUNNING) && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge key_reset) begin
    if (!key_reset) begin
      state    <= IDLE;
      presc    <= '0;
      frozen   <= 1'b0;
      clear_q  <= 1'b0;
      tick_tgl <= 1'b0;
    end else begin
      state   <= state_nx;
      presc   <= presc_nx;
      frozen  <= frozen_nx;
      clear_q <= clear_nx;
      if (sw.tick) tick_tgl <= !tick_tgl;
    end
  end

  always_comb begin
    state_nx  = state;
    presc_nx  = presc;
    frozen_nx = frozen;
    clear_nx  = 1'b0;
    if (state == RUNNING) presc_nx = wrap ? '0 : presc + CW'(1);
    if (press_cl) begin
      state_nx  = IDLE;
      presc_nx  = '0;
      frozen_nx = 1'b0;
      clear_nx  = 1'b1;
    end else if (go_sp) begin
      unique case (state)
        IDLE:    state_nx = RUNNING;
        RUNNING: state_nx = PAUSED;
        PAUSED:  state_nx = RUNNING;
        default: state_nx = IDLE;
      endcase
    end else if (go_ds) begin
      frozen_nx = !frozen;
    end
  end

  assign sw.tick    = wrap && !clear_q;
  assign sw.clear   = clear_q;
  assign sw.run     = (state == RUNNING);
  assign sw.disp_en = !frozen;
  assign sw.led     = {tick_tgl, frozen, state == PAUSED, state == RUNNING};

endmodule
